fir_tap_sequencer: RTL and testbench
====================================

// Module: fir_tap_sequencer
// PURPOSE
//  Input-side responder of the FIR sample handshake: accepts one sample per input_valid pulse,
//  stores it in a Taps-deep circular delay line, then streams the Taps newest samples
//  (newest first) with matching coefficient index to the MAC datapath.
//  Pulses output_valid when a sequence completes. Sits between the sample source and the FIR MAC.
// PARAMETERS
//  InputWidth  16                   sample width (two's complement)
//  Taps        64                   delay-line depth = taps per output
//  AddrWidth   $clog2(Taps) (=6)    pointer/coefficient index width
// PORTS
//  clk           in   1           single clock, rising edge
//  rst           in   1           asynchronous, active-high reset
//  din           in   InputWidth  sample, captured when input_valid=1 and ready=1
//  input_valid   in   1           one-cycle sample strobe from the source
//  ready         out  1           1 in IDLE only; the source may pulse input_valid only while it is 1
//  tap_sample    out  InputWidth  delay-line sample x[n-k]
//  coef_addr     out  AddrWidth   tap index k for the coefficient ROM
//  tap_valid     out  1           tap_sample/coef_addr valid this cycle
//  tap_first     out  1           k==0 (MAC clears accumulator)
//  tap_last      out  1           k==Taps-1
//  output_valid  out  1           one-cycle pulse: sequence for x[n] complete
//  overrun       out  1           sticky: sample arrived while busy
// BEHAVIOUR
//  Reset: state IDLE, wr_ptr=0, fill=0, all outputs 0 except ready=1; RAM contents not cleared.
//  FSM (fir_pkg::seq_state_t): IDLE -> buffer_addressing -> DONE -> IDLE.
//   IDLE: on edge E0 with input_valid: RAM[wr_ptr]<=din, base<=wr_ptr, wr_ptr<=wr_ptr+1 (mod Taps),
//         fill<=min(fill+1,Taps), k<=0, go buffer_addressing; ready drops after E0.
//   buffer_addressing: one read per cycle, rd_addr=(base-k) mod Taps (wraps 0->Taps-1), k++;
//         after issuing k=Taps-1 go DONE.
//   DONE: one cycle, output_valid=1, then IDLE.
//  Sync-read RAM: tap k is on the outputs after edge E0+2+k, so tap_valid is high for exactly Taps
//   consecutive cycles (edges E2..E65 for Taps=64); tap_first on k=0, tap_last on k=Taps-1.
//  output_valid pulses after edge E66 (Taps+2); ready returns 1 one cycle later (E67).
//   Throughput: one sample per Taps+3 cycles.
//  Unfilled taps: if k>=fill, tap_sample=0 (tap_valid still 1), so startup output equals zero history.
//  coef_addr=k; tap_sample=0 whenever tap_valid=0.
//  input_valid while ready=0: sample dropped; the sequence in flight is unaffected.
//  input_valid coinciding with the DONE->IDLE cycle: the sample is still dropped (ready=0).
//  Reset mid-sequence: immediate abort to reset values; no output_valid; history discarded (fill=0).
// CONFIGURATION
//  FIR_TAP_SEQ_OVERRUN_EN defined: an input_valid pulse while ready=0 sets overrun (sticky; cleared
//   only by rst).
//  Not defined: overrun tied to 0; dropped samples are silent. Nothing else changes.
// STRUCTURE
//  fir_pkg: seq_state_t enum {IDLE, buffer_addressing, DONE}; FIR_TAPS=64; FIR_IN_W=16.
//  Sub-module fir_sample_ram: 1 write / 1 read port, sync read, Taps x InputWidth, no reset.
//  Top: FSM, wr_ptr/base/k/fill counters, a one-cycle valid/first/last delay aligned to the RAM
//   read, zero-mask.
// TESTING
//  1 Impulse: after rst, samples 0x0001 then 0x0000 x2 -> seq1: k0=1, k1..63=0; seq3: k2=1, others 0.
//  2 Wrap: 70 samples with values 1..70 -> seq70: k0=70, k1=69, ..., k63=7 (base wraps through 0).
//  3 Timing: input_valid at E0 -> tap_valid is high on E2..E65 exactly (64 cycles),
//     output_valid is a single pulse after E66, ready=1 after E67.
//  4 Overrun: input_valid at E10 of a sequence -> sample not in the RAM; overrun=1 with the macro, 0
//     without; next sequence unaffected.
//  5 Reset mid-op: rst asserted after E20 -> all outputs 0 and ready=1 at once; next sample gives
//     k1..63=0.
//  6 Back-to-back: input_valid pulsed the cycle ready rises -> accepted; 100 such samples, no
//     loss, no overrun.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and default sizes for the FIR tap sequencer.
package fir_pkg;

    localparam int FIR_TAPS = 64;
    localparam int FIR_IN_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        buffer_addressing,
        DONE
    } seq_state_t;

endpackage

// File: rtl/fir_sample_ram.sv
// Sample delay-line storage: one write port, one synchronous read port, no reset.
module fir_sample_ram #(
    parameter int Depth     = 64,
    parameter int Width     = 16,
    parameter int AddrWidth = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AddrWidth-1:0] waddr,
    input  logic [Width-1:0]     wdata,
    input  logic [AddrWidth-1:0] raddr,
    output logic [Width-1:0]     rdata
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR input sequencer: stores samples in a circular delay line and streams the newest Taps
// samples, newest first, to the MAC. Define FIR_TAP_SEQ_OVERRUN_EN for the sticky overrun flag.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int InputWidth = FIR_IN_W,
    parameter int Taps       = FIR_TAPS,
    parameter int AddrWidth  = $clog2(Taps)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [InputWidth-1:0] din,
    input  logic                  input_valid,
    output logic                  ready,
    output logic [InputWidth-1:0] tap_sample,
    output logic [AddrWidth-1:0]  coef_addr,
    output logic                  tap_valid,
    output logic                  tap_first,
    output logic                  tap_last,
    output logic                  output_valid,
    output logic                  overrun
);

    localparam int FillWidth = AddrWidth + 1;
    localparam logic [AddrWidth-1:0] LAST_K = AddrWidth'(Taps - 1);

    seq_state_t state, state_nxt;

    logic [AddrWidth-1:0]  wr_ptr, base, k, k_d1, rd_addr;
    logic [FillWidth-1:0]  fill;
    logic [InputWidth-1:0] rd_data;
    logic [2:1]            vld_pipe;
    logic                  accept, issue, mask_d1, done_d1;

    // ready stays low until the delayed DONE has drained through the output stage
    assign ready     = (state == IDLE) & ~done_d1 & ~output_valid;
    assign accept    = input_valid & ready;
    assign tap_valid = vld_pipe[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE:              if (accept) state_nxt = buffer_addressing;
            buffer_addressing: begin
                issue = 1'b1;
                if (k == LAST_K) state_nxt = DONE;
            end
            DONE:              state_nxt = IDLE;
            default:           state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            base   <= '0;
            k      <= '0;
            fill   <= '0;
        end else if (accept) begin
            base   <= wr_ptr;
            wr_ptr <= (wr_ptr == LAST_K) ? '0 : wr_ptr + 1'b1;
            fill   <= (fill == FillWidth'(Taps)) ? fill : fill + 1'b1;
            k      <= '0;
        end else if (issue) begin
            k <= k + 1'b1;
        end
    end

    // (base - k) mod Taps, valid for non-power-of-two depths too
    always_comb begin
        if (base >= k) rd_addr = base - k;
        else           rd_addr = AddrWidth'(FillWidth'(base) + FillWidth'(Taps) - FillWidth'(k));
    end

    fir_sample_ram #(
        .Depth    (Taps),
        .Width    (InputWidth),
        .AddrWidth(AddrWidth)
    ) u_ram (
        .clk  (clk),
        .we   (accept),
        .waddr(wr_ptr),
        .wdata(din),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    // stage 1 tracks the RAM read, stage 2 is the registered output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe     <= '0;
            k_d1         <= '0;
            mask_d1      <= 1'b0;
            done_d1      <= 1'b0;
            tap_sample   <= '0;
            coef_addr    <= '0;
            tap_first    <= 1'b0;
            tap_last     <= 1'b0;
            output_valid <= 1'b0;
        end else begin
            vld_pipe[1]  <= issue;
            vld_pipe[2]  <= vld_pipe[1];
            k_d1         <= k;
            mask_d1      <= ({1'b0, k} >= fill);
            done_d1      <= (state == DONE);
            output_valid <= done_d1;
            tap_sample   <= (vld_pipe[1] & ~mask_d1) ? rd_data : '0;
            coef_addr    <= vld_pipe[1] ? k_d1 : '0;
            tap_first    <= vld_pipe[1] & (k_d1 == '0);
            tap_last     <= vld_pipe[1] & (k_d1 == LAST_K);
        end
    end

`ifdef FIR_TAP_SEQ_OVERRUN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       overrun <= 1'b0;
        else if (input_valid & ~ready) overrun <= 1'b1;
    end
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: impulse table, timing, overrun, reset abort, wrap.
module tb_fir_tap_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        input_valid;
    logic        ready;
    logic [15:0] tap_sample;
    logic [5:0]  coef_addr;
    logic        tap_valid, tap_first, tap_last, output_valid, overrun;

    fir_tap_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .input_valid (input_valid),
        .ready       (ready),
        .tap_sample  (tap_sample),
        .coef_addr   (coef_addr),
        .tap_valid   (tap_valid),
        .tap_first   (tap_first),
        .tap_last    (tap_last),
        .output_valid(output_valid),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [15:0] cap [64];
    int  nvalid, first_j, last_j, ov_j, ov_n, rdy_j;
    bit  order_ok, flag_ok, idle_ok;

    typedef struct {
        logic [15:0] din;
        int          k;
        int          exp_val;
        int          exp_nz;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int nonzero();
        int n = 0;
        for (int i = 0; i < 64; i++) if (cap[i] != 16'h0) n++;
        return n;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called on a negedge; sends v as soon as ready is seen, then observes one edge per negedge.
    task automatic run_seq(input logic [15:0] v, input int inj_j, input int rst_j);
        int w = 0;
        while (!ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", int'(ready), 1);
        din = v;
        input_valid = 1'b1;
        @(posedge clk);
        #1 input_valid = 1'b0;
        for (int i = 0; i < 64; i++) cap[i] = 16'hDEAD;
        nvalid = 0; first_j = -1; last_j = -1; ov_j = -1; ov_n = 0; rdy_j = -1;
        order_ok = 1'b1; flag_ok = 1'b1; idle_ok = 1'b1;
        for (int j = 0; j < 90; j++) begin
            @(negedge clk);
            if (j == rst_j) begin
                rst = 1'b1;
                #1;
                check("rst_tap_valid", int'(tap_valid), 0);
                check("rst_tap_sample", int'(tap_sample), 0);
                check("rst_coef_addr", int'(coef_addr), 0);
                check("rst_first_last", int'(tap_first | tap_last), 0);
                check("rst_output_valid", int'(output_valid), 0);
                check("rst_ready", int'(ready), 1);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (tap_valid) begin
                nvalid++;
                if (first_j < 0) first_j = j;
                last_j = j;
                if (int'(coef_addr) != nvalid - 1) order_ok = 1'b0;
                if (tap_first != (coef_addr == 6'd0)) flag_ok = 1'b0;
                if (tap_last != (coef_addr == 6'd63)) flag_ok = 1'b0;
                cap[coef_addr] = tap_sample;
            end else if (tap_sample != 16'h0 || tap_first || tap_last) begin
                idle_ok = 1'b0;
            end
            if (output_valid) begin
                ov_n++;
                ov_j = j;
            end
            if (j + 1 == inj_j) begin
                input_valid = 1'b1;
                din = 16'h7777;
            end else if (j == inj_j) begin
                input_valid = 1'b0;
            end
            if (ready) begin
                rdy_j = j;
                break;
            end
        end
    endtask

    task automatic check_timing();
        check("first_tap_cycle", first_j, 2);
        check("last_tap_cycle", last_j, 65);
        check("tap_valid_count", nvalid, 64);
        check("output_valid_cycle", ov_j, 66);
        check("output_valid_pulses", ov_n, 1);
        check("ready_return_cycle", rdy_j, 67);
        check("coef_order", int'(order_ok), 1);
        check("first_last_flags", int'(flag_ok), 1);
        check("idle_zero", int'(idle_ok), 1);
    endtask

    int exp_ovr;
    vec_t tbl [6];

    initial begin
        tbl[0] = '{16'h0001, 0, 1, 1};
        tbl[1] = '{16'h0000, 1, 1, 1};
        tbl[2] = '{16'h0000, 2, 1, 1};
        tbl[3] = '{16'h8000, 3, 1, 2};
        tbl[4] = '{16'hFFFF, 1, 16'h8000, 3};
        tbl[5] = '{16'h1234, 0, 16'h1234, 4};
`ifdef FIR_TAP_SEQ_OVERRUN_EN
        exp_ovr = 1;
`else
        exp_ovr = 0;
`endif

        rst = 1'b1; input_valid = 1'b0; din = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", int'(ready), 1);
        check("reset_tap_valid", int'(tap_valid), 0);
        check("reset_tap_sample", int'(tap_sample), 0);
        check("reset_coef_addr", int'(coef_addr), 0);
        check("reset_output_valid", int'(output_valid), 0);
        check("reset_overrun", int'(overrun), 0);
        rst = 1'b0;
        @(negedge clk);

        // impulse and mixed-value table
        for (int i = 0; i < 6; i++) begin
            run_seq(tbl[i].din, -1, -1);
            check_timing();
            check("tbl_k0", int'(cap[0]), int'(tbl[i].din));
            check("tbl_kval", int'(cap[tbl[i].k]), tbl[i].exp_val);
            check("tbl_nonzero", nonzero(), tbl[i].exp_nz);
        end
        check("no_overrun_yet", int'(overrun), 0);

        // sample arriving mid-sequence is dropped
        run_seq(16'h00AA, 10, -1);
        check_timing();
        check("overrun_flag", int'(overrun), exp_ovr);
        run_seq(16'h00BB, -1, -1);
        check_timing();
        check("after_ovr_k0", int'(cap[0]), 16'h00BB);
        check("after_ovr_k1", int'(cap[1]), 16'h00AA);
        check("after_ovr_k2", int'(cap[2]), 16'h1234);
        check("overrun_sticky", int'(overrun), exp_ovr);

        // reset mid-sequence discards history
        run_seq(16'h0055, -1, 20);
        check("rst_overrun_clear", int'(overrun), 0);
        run_seq(16'h0005, -1, -1);
        check_timing();
        check("post_rst_k0", int'(cap[0]), 5);
        check("post_rst_nonzero", nonzero(), 1);

        // back-to-back stream, wrapping the write pointer
        do_reset();
        for (int n = 1; n <= 100; n++) begin
            run_seq(16'(n), -1, -1);
            check_timing();
            if (n == 70) begin
                for (int k = 0; k < 64; k++) check("wrap_tap", int'(cap[k]), 70 - k);
            end else begin
                check("b2b_k0", int'(cap[0]), n);
                check("b2b_k1", int'(cap[1]), (n > 1) ? n - 1 : 0);
            end
            if (n == 10) begin
                check("fill10_k9", int'(cap[9]), 1);
                check("fill10_k63", int'(cap[63]), 0);
                check("fill10_nonzero", nonzero(), 10);
            end
        end
        check("b2b_no_overrun", int'(overrun), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
